// File: rtl/des_pkg.sv
// Shared types, permutation tables and helpers for the DES key schedule.
package des_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StRound,
        StDone
    } state_e;

    // Left-rotation amount for DES rounds 1..16, stored 0-based.
    localparam logic [1:0] SHIFT_TAB [16] = '{
        2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
        2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
    };

    // DES bit numbers (1 = MSB) feeding C and D.
    localparam int unsigned PC1_C_TAB [28] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36
    };

    localparam int unsigned PC1_D_TAB [28] = '{
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };

    // CD bit numbers (1 = MSB of the 56-bit CD) forming each subkey bit.
    localparam int unsigned PC2_TAB [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };

    function automatic logic [27:0] pc1_c(input logic [63:0] k);
        logic [27:0] c;
        for (int i = 0; i < 28; i++) begin
            c[27-i] = k[64-PC1_C_TAB[i]];
        end
        return c;
    endfunction

    function automatic logic [27:0] pc1_d(input logic [63:0] k);
        logic [27:0] d;
        for (int i = 0; i < 28; i++) begin
            d[27-i] = k[64-PC1_D_TAB[i]];
        end
        return d;
    endfunction

    function automatic logic [47:0] pc2(input logic [55:0] cd);
        logic [47:0] o;
        for (int i = 0; i < 48; i++) begin
            o[47-i] = cd[56-PC2_TAB[i]];
        end
        return o;
    endfunction

    // idx is the 0-based round index (round n -> n-1).
    function automatic logic [1:0] shift_amt(input logic [3:0] idx);
        return SHIFT_TAB[idx];
    endfunction

    // True when every byte of the key has odd parity.
    function automatic logic odd_parity_ok(input logic [63:0] k);
        logic ok;
        ok = 1'b1;
        for (int b = 0; b < 8; b++) begin
            ok = ok & (^k[8*b +: 8]);
        end
        return ok;
    endfunction

endpackage

// File: rtl/des_cd_rot.sv
// Combinational rotator for the DES CD register: C and D rotate independently.
// dir_i = 0 rotates left (encrypt order), dir_i = 1 rotates right (decrypt order).
module des_cd_rot (
    input  logic [55:0] cd_i,
    input  logic        dir_i,
    input  logic [1:0]  amt_i,
    output logic [55:0] cd_o
);

    function automatic logic [27:0] rot28(input logic [27:0] v, input logic right,
                                          input logic [1:0] amt);
        logic [55:0] dbl;
        if (right) begin
            dbl = {v, v} >> amt;
            return dbl[27:0];
        end
        dbl = {v, v} << amt;
        return dbl[55:28];
    endfunction

    assign cd_o = {rot28(cd_i[55:28], dir_i, amt_i), rot28(cd_i[27:0], dir_i, amt_i)};

endmodule

// File: rtl/des_key_sched.sv
// DES/3DES key-schedule generator streaming 16 subkeys per key over valid/ready.
// Optional odd-parity key check enabled by defining DES_KEY_SCHED_PARITY_CHECK_EN.
module des_key_sched
    import des_pkg::*;
#(
    parameter int unsigned NUM_KEYS = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   decrypt,
    input  logic [64*NUM_KEYS-1:0] key,
    input  logic                   kn_ready,
    output logic                   kn_valid,
    output logic [47:0]            kn,
    output logic [3:0]             kn_round,
    output logic [1:0]             kn_key,
    output logic                   kn_last,
    output logic                   busy,
    output logic                   done,
    output logic                   key_err
);

    localparam logic [1:0] LastStage = 2'(NUM_KEYS - 1);

    state_e                 state_q, state_d;
    logic [1:0]             stage_q, stage_d;
    logic [3:0]             count_q, count_d;
    logic                   dec_q, dec_d;
    logic [64*NUM_KEYS-1:0] key_q, key_d;
    logic [55:0]            cd_q, cd_d;

    logic        in_load, in_round, dir;
    logic [1:0]  key_idx;
    logic [63:0] key_sel;
    logic [55:0] rot_in, rot_out;
    logic [1:0]  rot_amt;
    logic [3:0]  shift_idx;

`ifdef DES_KEY_SCHED_PARITY_CHECK_EN
    logic err_q, err_d, par_ok;

    // All incoming keys must have odd parity in every byte.
    always_comb begin
        par_ok = 1'b1;
        for (int unsigned k = 0; k < NUM_KEYS; k++) begin
            par_ok = par_ok & odd_parity_ok(key[64*k +: 64]);
        end
    end
`endif

    assign in_load  = (state_q == StLoad);
    assign in_round = (state_q == StRound);
    // Middle stage of EDE runs opposite to the schedule direction.
    assign dir      = dec_q ^ (stage_q == 2'd1);
    assign key_idx  = dec_q ? (LastStage - stage_q) : stage_q;

    // Select the active stage's key; decrypt walks the keys backwards.
    always_comb begin
        key_sel = key_q[63:0];
        for (int unsigned k = 0; k < NUM_KEYS; k++) begin
            if (key_idx == 2'(k)) key_sel = key_q[64*k +: 64];
        end
    end

    // Rotator input: fresh PC-1 on LOAD, otherwise advance CD to the next round.
    always_comb begin
        shift_idx = dir ? (4'd15 - count_q) : (count_q + 4'd1);
        if (in_load) begin
            rot_in  = {pc1_c(key_sel), pc1_d(key_sel)};
            // Reverse starts at C16D16 == C0D0, so no rotation is needed.
            rot_amt = dir ? 2'd0 : 2'd1;
        end else begin
            rot_in  = cd_q;
            rot_amt = shift_amt(shift_idx);
        end
    end

    des_cd_rot u_cd_rot (
        .cd_i  (rot_in),
        .dir_i (dir),
        .amt_i (rot_amt),
        .cd_o  (rot_out)
    );

    // Next-state logic for the schedule sequencer.
    always_comb begin
        state_d = state_q;
        stage_d = stage_q;
        count_d = count_q;
        dec_d   = dec_q;
        key_d   = key_q;
        cd_d    = cd_q;
`ifdef DES_KEY_SCHED_PARITY_CHECK_EN
        err_d   = err_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    key_d   = key;
                    dec_d   = decrypt;
                    stage_d = 2'd0;
                    count_d = 4'd0;
                    state_d = StLoad;
`ifdef DES_KEY_SCHED_PARITY_CHECK_EN
                    err_d   = ~par_ok;
                    if (!par_ok) state_d = StDone;
`endif
                end
            end
            StLoad: begin
                cd_d    = rot_out;
                state_d = StRound;
            end
            StRound: begin
                if (kn_ready) begin
                    if (count_q != 4'd15) begin
                        count_d = count_q + 4'd1;
                        cd_d    = rot_out;
                    end else if (stage_q != LastStage) begin
                        stage_d = stage_q + 2'd1;
                        count_d = 4'd0;
                        state_d = StLoad;
                    end else begin
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Control registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            stage_q <= 2'd0;
            count_q <= 4'd0;
            dec_q   <= 1'b0;
`ifdef DES_KEY_SCHED_PARITY_CHECK_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            stage_q <= stage_d;
            count_q <= count_d;
            dec_q   <= dec_d;
`ifdef DES_KEY_SCHED_PARITY_CHECK_EN
            err_q   <= err_d;
`endif
        end
    end

    // Key and CD datapath; contents are never visible outside ROUND.
    always_ff @(posedge clk) begin
        key_q <= key_d;
        cd_q  <= cd_d;
    end

    // Outputs are registered-state only, so kn_ready never reaches kn/kn_valid.
    always_comb begin
        kn_valid = in_round;
        kn       = '0;
        kn_round = '0;
        kn_key   = '0;
        kn_last  = 1'b0;
        if (in_round) begin
            kn       = pc2(cd_q);
            kn_round = dir ? (4'd15 - count_q) : count_q;
            kn_key   = stage_q;
            kn_last  = (stage_q == LastStage) && (count_q == 4'd15);
        end
        busy = (state_q != StIdle);
        done = (state_q == StDone);
`ifdef DES_KEY_SCHED_PARITY_CHECK_EN
        key_err = done & err_q;
`else
        key_err = 1'b0;
`endif
    end

endmodule

// File: tb/tb_des_key_sched.sv
// Scoreboard bench for des_key_sched with single-DES and 3DES instances.
module tb_des_key_sched;

    localparam int PC1 [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };
    localparam int PC2 [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };
    localparam int SHIFTS [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

    localparam logic [63:0] KNOWN  = 64'h133457799BBCDFF1;
    localparam logic [63:0] WEAK   = 64'h0101010101010101;
    localparam logic [63:0] BADPAR = 64'h133457799BBCDFF0;

    typedef struct packed {
        logic [47:0] kn;
        logic [3:0]  rnd;
        logic [1:0]  key;
        logic        last;
    } exp_t;

    logic         clk, rst, decrypt, kn_ready;
    logic         start1, start3;
    logic [63:0]  key1;
    logic [191:0] key3;
    logic         v1, v3, last1, last3, busy1, busy3, done1, done3, err1, err3;
    logic [47:0]  kn1, kn3;
    logic [3:0]   rnd1, rnd3;
    logic [1:0]   kk1, kk3;

    bit           act;
    logic         m_valid, m_last, m_busy, m_done, m_err;
    logic [47:0]  m_kn;
    logic [3:0]   m_round;
    logic [1:0]   m_key;

    exp_t         sb_q[$];
    int           checks = 0, errors = 0, cyc = 0;
    int           t_start, stalls, exp_delay, accepted;
    bit           pend = 0, exp_err, seen_first, rand_ready = 0;
    logic [47:0]  first_kn, last_kn;
    logic [3:0]   first_rnd, last_rnd;
    logic         last_flag;

    des_key_sched #(.NUM_KEYS(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .decrypt(decrypt), .key(key1),
        .kn_ready(kn_ready), .kn_valid(v1), .kn(kn1), .kn_round(rnd1), .kn_key(kk1),
        .kn_last(last1), .busy(busy1), .done(done1), .key_err(err1)
    );

    des_key_sched #(.NUM_KEYS(3)) u_dut3 (
        .clk(clk), .rst(rst), .start(start3), .decrypt(decrypt), .key(key3),
        .kn_ready(kn_ready), .kn_valid(v3), .kn(kn3), .kn_round(rnd3), .kn_key(kk3),
        .kn_last(last3), .busy(busy3), .done(done3), .key_err(err3)
    );

    assign m_valid = act ? v3 : v1;
    assign m_kn    = act ? kn3 : kn1;
    assign m_round = act ? rnd3 : rnd1;
    assign m_key   = act ? kk3 : kk1;
    assign m_last  = act ? last3 : last1;
    assign m_busy  = act ? busy3 : busy1;
    assign m_done  = act ? done3 : done1;
    assign m_err   = act ? err3 : err1;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog act=running exp=finished");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] actual, input logic [63:0] expd);
        checks++;
        if (actual !== expd) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, actual, expd);
        end
    endtask

    // Round r (0-based) subkey: PC-2 of C,D rotated by the cumulative shift count.
    function automatic logic [47:0] model_subkey(input logic [63:0] k, input int r);
        logic [27:0] c0, d0, c, d;
        logic [55:0] cd;
        logic [47:0] o;
        int tot;
        for (int j = 0; j < 28; j++) begin
            c0[27-j] = k[64-PC1[j]];
            d0[27-j] = k[64-PC1[28+j]];
        end
        tot = 0;
        for (int n = 0; n <= r; n++) tot += SHIFTS[n];
        for (int j = 0; j < 28; j++) begin
            c[27-j] = c0[27-((j + tot) % 28)];
            d[27-j] = d0[27-((j + tot) % 28)];
        end
        cd = {c, d};
        for (int j = 0; j < 48; j++) o[47-j] = cd[56-PC2[j]];
        return o;
    endfunction

    function automatic bit par_ok(input logic [63:0] k);
        bit ok;
        ok = 1;
        for (int b = 0; b < 8; b++) if (!(^k[8*b +: 8])) ok = 0;
        return ok;
    endfunction

    function automatic logic [63:0] rk();
        logic [63:0] k;
        k = {$urandom, $urandom};
        for (int b = 0; b < 8; b++) k[8*b] = ~^k[8*b+1 +: 7];
        return k;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int g;
        g = 0;
        while ((busy1 || busy3) && g < 200) begin
            tick();
            g++;
        end
        chk("idle_before_start", {62'd0, busy1, busy3}, 64'd0);
    endtask

    task automatic start_sched(input bit a, input logic [191:0] keys, input logic dec);
        int   n, ki;
        bit   bad, dir;
        exp_t e;
        wait_idle();
        n   = a ? 3 : 1;
        act = a;
        bad = 0;
`ifdef DES_KEY_SCHED_PARITY_CHECK_EN
        for (int k = 0; k < n; k++) if (!par_ok(keys[64*k +: 64])) bad = 1;
`endif
        if (!bad) begin
            for (int s = 0; s < n; s++) begin
                dir = dec ^ (s == 1);
                ki  = dec ? (n - 1 - s) : s;
                for (int i = 0; i < 16; i++) begin
                    e.rnd  = 4'(dir ? 15 - i : i);
                    e.kn   = model_subkey(keys[64*ki +: 64], int'(e.rnd));
                    e.key  = 2'(s);
                    e.last = (s == n - 1) && (i == 15);
                    sb_q.push_back(e);
                end
            end
        end
        exp_delay = bad ? 1 : 1 + 17 * n;
        exp_err   = bad;
        key1      = keys[63:0];
        key3      = keys;
        decrypt   = dec;
        if (a) start3 = 1'b1;
        else   start1 = 1'b1;
        t_start    = cyc;
        stalls     = 0;
        accepted   = 0;
        seen_first = 0;
        pend       = 1;
        tick();
        start1 = 1'b0;
        start3 = 1'b0;
    endtask

    task automatic wait_done();
        int g;
        g = 0;
        while (pend && g < 2000) begin
            tick();
            g++;
        end
        chk("done_timeout", {63'd0, pend}, 64'd0);
        if (pend) begin
            rst = 1'b1;
            tick();
            rst = 1'b0;
            pend = 0;
            sb_q.delete();
        end
    endtask

    // Ready generator: always high unless backpressure is requested.
    initial begin
        kn_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            kn_ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
    end

    // Monitor: pops the scoreboard on every accepted subkey and checks done timing.
    initial begin
        bit          prev_stall;
        logic [55:0] prev_vec, cur_vec;
        exp_t        e;
        prev_stall = 0;
        prev_vec   = '0;
        forever begin
            @(negedge clk);
            cur_vec = {m_valid, m_last, m_key, m_round, m_kn};
            if (rst) begin
                prev_stall = 0;
            end else begin
                if (prev_stall) chk("stall_hold", 64'(cur_vec), 64'(prev_vec));
                if (m_valid) begin
                    if (!seen_first) begin
                        seen_first = 1;
                        first_kn   = m_kn;
                        first_rnd  = m_round;
                        chk("first_latency", 64'(cyc - t_start), 64'd2);
                    end
                    if (kn_ready) begin
                        chk("sb_nonempty", {63'd0, sb_q.size() != 0}, 64'd1);
                        if (sb_q.size() != 0) begin
                            e = sb_q.pop_front();
                            chk("kn", 64'(m_kn), 64'(e.kn));
                            chk("tags", {57'd0, m_round, m_key, m_last},
                                {57'd0, e.rnd, e.key, e.last});
                        end
                        accepted++;
                        last_kn   = m_kn;
                        last_rnd  = m_round;
                        last_flag = m_last;
                    end else begin
                        stalls++;
                    end
                end
                if (m_err) chk("key_err_with_done", {63'd0, m_done}, 64'd1);
                if (m_done) begin
                    chk("done_expected", {63'd0, pend}, 64'd1);
                    if (pend) begin
                        chk("done_latency", 64'(cyc - t_start), 64'(exp_delay + stalls));
                        chk("key_err", {63'd0, m_err}, {63'd0, exp_err});
                        chk("sb_drained", 64'(sb_q.size()), 64'd0);
                        pend = 0;
                    end
                end
                prev_stall = m_valid && !kn_ready;
                prev_vec   = cur_vec;
            end
        end
    end

    initial begin
        logic [191:0] keys;
        int           g;
        rst = 1'b1;
        start1 = 1'b0;
        start3 = 1'b0;
        decrypt = 1'b0;
        key1 = '0;
        key3 = '0;
        act = 0;
        repeat (3) tick();
        chk("reset_dut1", {5'd0, v1, kn1, rnd1, kk1, last1, busy1, done1, err1}, 64'd0);
        chk("reset_dut3", {5'd0, v3, kn3, rnd3, kk3, last3, busy3, done3, err3}, 64'd0);
        rst = 1'b0;
        tick();

        // Known single-DES vector, encrypt order.
        start_sched(0, {128'd0, KNOWN}, 1'b0);
        wait_done();
        chk("fwd_first_kn", 64'(first_kn), 64'h1B02EFFC7072);
        chk("fwd_first_round", 64'(first_rnd), 64'd0);
        chk("fwd_last_kn", 64'(last_kn), 64'hCB3D8B0E17F5);
        chk("fwd_last_round", 64'(last_rnd), 64'd15);
        chk("fwd_last_flag", {63'd0, last_flag}, 64'd1);

        // Same key, decrypt order.
        start_sched(0, {128'd0, KNOWN}, 1'b1);
        wait_done();
        chk("dec_first_kn", 64'(first_kn), 64'hCB3D8B0E17F5);
        chk("dec_first_round", 64'(first_rnd), 64'd15);
        chk("dec_last_kn", 64'(last_kn), 64'h1B02EFFC7072);
        chk("dec_last_round", 64'(last_rnd), 64'd0);

        // 3DES with weak keys: 48 zero subkeys, stages 0,1,2.
        start_sched(1, {WEAK, WEAK, WEAK}, 1'b0);
        wait_done();
        chk("weak_count", 64'(accepted), 64'd48);

        // Parity-bad key: rejected only when the check is built in.
        start_sched(0, {128'd0, BADPAR}, 1'b0);
        wait_done();
`ifdef DES_KEY_SCHED_PARITY_CHECK_EN
        chk("badpar_count", 64'(accepted), 64'd0);
`else
        chk("badpar_count", 64'(accepted), 64'd16);
`endif

        // Random keys/directions under backpressure.
        rand_ready = 1;
        start_sched(0, {128'd0, KNOWN}, 1'b0);
        wait_done();
        for (int i = 0; i < 8; i++) begin
            start_sched(i[0], {rk(), rk(), rk()}, 1'($urandom_range(0, 1)));
            wait_done();
        end

        // Reset during round 7 of a 3DES schedule.
        rand_ready = 0;
        kn_ready = 1'b1;
        tick();
        keys = {rk(), rk(), rk()};
        start_sched(1, keys, 1'b0);
        g = 0;
        while (!(m_valid && m_round == 4'd7) && g < 100) begin
            tick();
            g++;
        end
        chk("round7_seen", {63'd0, m_valid && m_round == 4'd7}, 64'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        pend = 0;
        sb_q.delete();
        chk("midrst_outs", {5'd0, m_valid, m_kn, m_round, m_key, m_last, m_busy, m_done, m_err},
            64'd0);
        repeat (25) tick();
        start_sched(1, keys, 1'b1);
        wait_done();
        chk("post_rst_count", 64'(accepted), 64'd48);

        repeat (3) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
